program_loader: RTL and testbench

- Upstream feeder for the multicycle computer's program-load path.
- Accepts a framed byte stream (sync, word count, instruction bytes, checksum) over a valid/ready handshake.
- Assembles 27-bit instruction words and drives program_mode, external_write_data and address with a one-cycle write strobe per word.
- Reports completion or framing/checksum errors so the computer is released from program mode only after a clean load.

---
 rtl/computer_pkg.sv | 18 +
 rtl/word_assembler.sv | 57 +++++
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared constants and the program-loader state encoding for the multicycle computer.
// Widths match the instruction memory and program counter.
package computer_pkg;

    localparam int         INSTR_ADDR_W  = 14;
    localparam int         INSTR_DATA_W  = 27;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_WORD   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5
    } ld_state_e;

endpackage

// File: rtl/word_assembler.sv
// Collects four big-endian bytes into one instruction word and keeps the frame XOR checksum.
// word_ready_o is combinational with the 4th byte; the word is valid in the same cycle.
module word_assembler
    import computer_pkg::*;
#(
    parameter int DATA_W = INSTR_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_ready_o,
    output logic [7:0]        chk_o
);

    // Holds {b0[2:0], b1, b2}; the upper bits of b0 never reach the word.
    logic [18:0] sr_q, sr_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        chk_d = chk_q;
        if (clear_i) begin
            chk_d = '0;
        end
        if (start_i) begin
            idx_d = '0;
        end
        if (byte_vld_i) begin
            sr_d  = {sr_q[10:0], byte_i};
            idx_d = idx_q + 2'd1;
            chk_d = chk_q ^ byte_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            idx_q <= '0;
            chk_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
            chk_q <= chk_d;
        end
    end

    assign word_o       = DATA_W'({sr_q, byte_i});
    assign word_ready_o = byte_vld_i && (idx_q == 2'd3);
    assign chk_o        = chk_q;

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: sync, 14-bit word count, 4 bytes per word, XOR checksum.
// One byte per cycle max; in_ready drops only in the WRITE cycle; stalls on in_valid gaps indefinitely.
module program_loader
    import computer_pkg::*;
#(
    parameter int                ADDR_W    = INSTR_ADDR_W,
    parameter int                DATA_W    = INSTR_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 16384,
    parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              program_mode,
    output logic [DATA_W-1:0] external_write_data,
    output logic [ADDR_W-1:0] address,
    output logic              prog_write,
    output logic              done,
    output logic              error
);

    ld_state_e         state_q, state_d;
    logic [5:0]        cnt_hi_q, cnt_hi_d;
    logic [13:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pmode_q, pmode_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              rdy_q, rdy_d;

    logic              accept;
    logic              clear_chk;
    logic              start_word;
    logic              word_vld;
    logic [13:0]       cnt_w;
    logic [DATA_W-1:0] asm_word;
    logic              asm_ready;
    logic [7:0]        asm_chk;

    assign accept = in_valid && rdy_q;
    assign cnt_w  = {cnt_hi_q, in_data};

    word_assembler #(
        .DATA_W (DATA_W)
    ) u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_chk),
        .start_i      (start_word),
        .byte_vld_i   (word_vld),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_ready_o (asm_ready),
        .chk_o        (asm_chk)
    );

    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pmode_d    = pmode_q;
        done_d     = 1'b0;
        error_d    = error_q;
        clear_chk  = 1'b0;
        start_word = 1'b0;
        word_vld   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    error_d   = 1'b0;
                    clear_chk = 1'b1;
                    addr_d    = BASE_ADDR;
                    state_d   = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = in_data[5:0];
                    state_d  = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    if ((cnt_w == '0) || ({18'd0, cnt_w} > 32'(MAX_WORDS))) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        remain_d   = cnt_w;
                        pmode_d    = 1'b1;
                        start_word = 1'b1;
                        state_d    = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                word_vld = accept;
                if (asm_ready) begin
                    wdata_d = asm_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 14'd1;
                state_d  = (remain_q == 14'd1) ? ST_CHECK : ST_WORD;
            end
            ST_CHECK: begin
                if (accept) begin
                    pmode_d = 1'b0;
                    state_d = ST_IDLE;
                    if (in_data == asm_chk) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so in_ready is low while reset is asserted.
        rdy_d = (state_d != ST_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_hi_q <= '0;
            remain_q <= '0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            pmode_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            pmode_q  <= pmode_d;
            done_q   <= done_d;
            error_q  <= error_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready            = rdy_q;
    assign program_mode        = pmode_q;
    assign external_write_data = wdata_q;
    assign address             = addr_q;
    assign prog_write          = (state_q == ST_WRITE);
    assign done                = done_q;
    assign error               = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard (MAX_WORDS reduced to 16).
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        program_mode;
    logic [26:0] external_write_data;
    logic [13:0] address;
    logic        prog_write;
    logic        done;
    logic        error;

    program_loader #(
        .ADDR_W    (14),
        .DATA_W    (27),
        .BASE_ADDR (14'd0),
        .MAX_WORDS (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .program_mode        (program_mode),
        .external_write_data (external_write_data),
        .address             (address),
        .prog_write          (prog_write),
        .done                (done),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] a;
        logic [26:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] wb[64];
    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    bit         gaps     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard and done counter, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset && prog_write) begin
            wr_t e;
            check("wr_in_ready", 32'(in_ready), 32'd0);
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL wr_unexpected observed addr=%0h data=%0h expected none", address, external_write_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(address), 32'(e.a));
                check("wr_data", 32'(external_write_data), 32'(e.d));
            end
        end
        if (!reset && done) done_cnt++;
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_two();
        wb[0] = 8'h05; wb[1] = 8'h12; wb[2] = 8'h34; wb[3] = 8'h56;
        wb[4] = 8'h00; wb[5] = 8'h00; wb[6] = 8'h00; wb[7] = 8'h07;
    endtask

    task automatic frame(input int n, input logic [7:0] chi, input logic [7:0] clo, input bit bad);
        logic [7:0] c;
        logic [7:0] tx;
        int         d0;
        wr_t        e;
        c  = 8'h00;
        d0 = done_cnt;
        send(8'hA5);
        check("sync_err_clr", 32'(error), 32'd0);
        send(chi);
        send(clo);
        check("pmode_up", 32'(program_mode), 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) begin
                    e.a = 14'(i);
                    e.d = {wb[4*i][2:0], wb[4*i+1], wb[4*i+2], wb[4*i+3]};
                    exp_q.push_back(e);
                end
                send(wb[4*i+k]);
                c = c ^ wb[4*i+k];
            end
        end
        check("pmode_at_chk", 32'(program_mode), 32'd1);
        tx = bad ? 8'h00 : c;
        send(tx);
        check("pmode_drop", 32'(program_mode), 32'd0);
        check("done", 32'(done), 32'(tx == c));
        check("error", 32'(error), 32'(tx != c));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_pulse_len", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'(tx == c));
    endtask

    task automatic bad_count(input logic [7:0] chi, input logic [7:0] clo);
        send(8'hA5);
        send(chi);
        send(clo);
        check("badcnt_err", 32'(error), 32'd1);
        check("badcnt_pmode", 32'(program_mode), 32'd0);
        check("badcnt_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_pmode"}, 32'(program_mode), 32'd0);
        check({tag, "_data"}, 32'(external_write_data), 32'd0);
        check({tag, "_addr"}, 32'(address), 32'd0);
        check({tag, "_write"}, 32'(prog_write), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        load_two();
        frame(2, 8'h00, 8'h02, 1'b0);
        frame(2, 8'h00, 8'h02, 1'b1);

        check("err_sticky", 32'(error), 32'd1);
        send(8'h00); send(8'hFF); send(8'h5A);
        check("err_after_garbage", 32'(error), 32'd1);
        frame(2, 8'h00, 8'h02, 1'b0);

        bad_count(8'h00, 8'h00);
        bad_count(8'h00, 8'h11);

        gaps = 1'b1;
        frame(2, 8'hC0, 8'h02, 1'b0);
        gaps = 1'b0;

        send(8'hA5); send(8'h00); send(8'h02); send(8'h05); send(8'h12);
        #2 reset = 1'b1;
        #1 reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame(2, 8'h00, 8'h02, 1'b0);

        for (int i = 0; i < 64; i++) wb[i] = 8'($urandom);
        wb[5] = 8'hA5;
        wb[8] = 8'hA5;
        frame(16, 8'h00, 8'h10, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
